// File: rtl/load_store_unit_pkg.sv
// lsu_pkg: funct3 codes, FSM states and the byte-swap helper shared by the load/store unit.
package lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} lsu_state_t;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core request/response and data-memory signals of the load/store unit.
interface load_store_unit_if #(parameter int ADDR_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_error;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_write_enable;
    logic [31:0]       mem_write_data;
    logic [31:0]       mem_read_data;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_error, mem_addr, mem_write_enable, mem_write_data
    );
    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_error, mem_addr, mem_write_enable, mem_write_data
    );
endinterface

// File: rtl/load_store_unit_byte_lane.sv
// lsu_byte_lane: load extraction/extension and sub-word store merge between memory and register byte order.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] rd,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged
);
    logic [31:0] reg_word;

    always_comb begin
        reg_word = bswap32(rd);
        load_val = funct3 == F3_B  ? {{24{reg_word[7]}}, reg_word[7:0]} :
                   funct3 == F3_BU ? {24'b0, reg_word[7:0]} :
                   funct3 == F3_H  ? {{16{reg_word[15]}}, reg_word[15:0]} :
                   funct3 == F3_HU ? {16'b0, reg_word[15:0]} : reg_word;
        merged   = funct3 == F3_B ? {wdata[7:0], rd[23:0]} :
                   funct3 == F3_H ? {wdata[7:0], wdata[15:8], rd[15:0]} : bswap32(wdata);
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RISC-V loads/stores onto a byte-addressed word memory; SB/SH run as read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned or out-of-range accesses with resp_error.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 4096
) (
    input logic              clock,
    input logic              reset,
    load_store_unit_if.slave bus
);
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_BYTES);

    lsu_state_t        state_q, state_d;
    logic              write_q, write_d, we_q, we_d, err_q, err_d;
    logic              resp_valid_q, resp_valid_d, resp_error_q, resp_error_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [31:0]       wdata_q, wdata_d, mem_wdata_q, mem_wdata_d;
    logic [31:0]       data_q, data_d, resp_rdata_q, resp_rdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       load_val, merged;
    logic              bad_f3, misaligned, out_of_range, reject;

    lsu_byte_lane lane (
        .funct3  (funct3_q),
        .rd      (bus.mem_read_data),
        .wdata   (wdata_q),
        .load_val(load_val),
        .merged  (merged)
    );

    always_comb begin
        bad_f3       = bus.req_funct3 inside {3'b011, 3'b110, 3'b111} || (bus.req_write && bus.req_funct3[2]);
        misaligned   = (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
                       (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
        out_of_range = {1'b0, bus.req_addr} + (ADDR_W+1)'(3) >= LIMIT;
        reject       = bad_f3 || (TRAP && (misaligned || out_of_range));
    end

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        funct3_d     = funct3_q;
        wdata_d      = wdata_q;
        mem_addr_d   = mem_addr_q;
        we_d         = 1'b0;
        mem_wdata_d  = mem_wdata_q;
        data_d       = data_q;
        err_d        = err_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_error_d = resp_error_q;
        unique case (state_q)
            IDLE: if (bus.req_valid) begin
                write_d      = bus.req_write;
                funct3_d     = bus.req_funct3;
                wdata_d      = bus.req_wdata;
                mem_addr_d   = bus.req_addr;
                err_d        = reject;
                resp_error_d = 1'b0;
                state_d      = reject ? RESP : ACCESS;
                we_d         = !reject && bus.req_write && bus.req_funct3 == F3_W;
                mem_wdata_d  = we_d ? bswap32(bus.req_wdata) : mem_wdata_q;
            end
            ACCESS: begin
                data_d      = load_val;
                we_d        = write_q && funct3_q != F3_W;
                mem_wdata_d = we_d ? merged : mem_wdata_q;
                state_d     = we_d ? WRITE : RESP;
            end
            WRITE: state_d = RESP;
            RESP: begin
                state_d      = IDLE;
                resp_valid_d = 1'b1;
                resp_rdata_d = write_q || err_q ? 32'b0 : data_q;
                resp_error_d = err_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            funct3_q     <= 3'b0;
            wdata_q      <= 32'b0;
            mem_addr_q   <= '0;
            we_q         <= 1'b0;
            mem_wdata_q  <= 32'b0;
            data_q       <= 32'b0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'b0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            funct3_q     <= funct3_d;
            wdata_q      <= wdata_d;
            mem_addr_q   <= mem_addr_d;
            we_q         <= we_d;
            mem_wdata_q  <= mem_wdata_d;
            data_q       <= data_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
        end
    end

    // Reset masks the write strobe immediately so an interrupted RMW never lands in memory.
    assign bus.mem_write_enable = we_q && !reset;
    assign bus.req_ready        = state_q == IDLE && !reset;
    assign bus.mem_addr         = mem_addr_q;
    assign bus.mem_write_data   = mem_wdata_q;
    assign bus.resp_valid       = resp_valid_q;
    assign bus.resp_rdata       = resp_rdata_q;
    assign bus.resp_error       = resp_error_q;
endmodule
